// File: rtl/memory_ram_sdp.sv
`default_nettype none
// ============================================================================
// Module      : memory_ram_sdp
// Description : Simple dual-port RAM with one write port and one read port on
//               a single clock. The read port can be configured for
//               read-first, write-first or no-change behaviour on a
//               same-address collision. An optional output register is
//               available. An optional zero-fill sweep runs after reset.
//
// Ports       : clk            - clock; all state changes on the rising edge
//               resetn         - asynchronous active-low reset
//               write_en       - write request for this cycle
//               write_address  - write location (DEPTH_BITS)
//               write_data_in  - write data (WIDTH)
//               read_en        - read request for this cycle
//               read_address   - read location (DEPTH_BITS)
//               read_data_out  - registered read data (WIDTH)
//               read_valid     - one-cycle pulse aligned with read data
//               init_busy      - high while the zero-fill sweep runs
//               collision      - one-cycle pulse, one cycle after an accepted
//                                same-address read and write
//
// Revision    : 1.0 - initial release
// ============================================================================
module memory_ram_sdp #(
    parameter int WIDTH          = 8,
    parameter int DEPTH_BITS     = 2,
    parameter int READ_MODE      = 0,
    parameter int OUT_REG        = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  write_en,
    input  logic [DEPTH_BITS-1:0] write_address,
    input  logic [WIDTH-1:0]      write_data_in,
    input  logic                  read_en,
    input  logic [DEPTH_BITS-1:0] read_address,
    output logic [WIDTH-1:0]      read_data_out,
    output logic                  read_valid,
    output logic                  init_busy,
    output logic                  collision
);

    localparam int                    c_DEPTH     = 1 << DEPTH_BITS;
    localparam logic [DEPTH_BITS-1:0] c_LAST_ADDR = '1;

    // Controller states
    localparam logic [0:0] c_ST_CLEAR = 1'b0;
    localparam logic [0:0] c_ST_RUN   = 1'b1;
    localparam logic [0:0] c_ST_RESET = (CLEAR_ON_RESET != 0) ? c_ST_CLEAR : c_ST_RUN;

    // ------------------------------------------------------------------------
    // Storage and control registers
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0]      r_mem [c_DEPTH];
    logic [0:0]            r_state;
    logic [DEPTH_BITS-1:0] r_sweep_addr;
    logic                  r_s1_valid;
    logic [WIDTH-1:0]      r_s1_data;
    logic                  r_coll;

    // ------------------------------------------------------------------------
    // Request qualification
    // ------------------------------------------------------------------------
    logic                  w_run;
    logic                  w_sweep;
    logic                  w_wr_accept;
    logic                  w_rd_accept;
    logic                  w_hit;
    logic                  w_rd_fire;
    logic [WIDTH-1:0]      w_rd_value;
    logic                  w_mem_we;
    logic [DEPTH_BITS-1:0] w_mem_waddr;
    logic [WIDTH-1:0]      w_mem_wdata;

    // Gating with resetn keeps the array untouched while reset is held: the
    // only way memory gets zeroed is the sweep after reset is released.
    assign w_run       = (r_state == c_ST_RUN)   && resetn;
    assign w_sweep     = (r_state == c_ST_CLEAR) && resetn;
    assign w_wr_accept = w_run && write_en;
    assign w_rd_accept = w_run && read_en;
    assign w_hit       = w_wr_accept && w_rd_accept && (read_address == write_address);

    // No-change mode drops a colliding read entirely; the write still lands.
    assign w_rd_fire   = w_rd_accept && !((READ_MODE == 2) && w_hit);

    // The array is read before this edge's write takes effect, so the plain
    // array value is the "old" data; write-first substitutes the new data.
    always_comb begin
        w_rd_value = r_mem[read_address];
        if ((READ_MODE == 1) && w_hit) begin
            w_rd_value = write_data_in;
        end
    end

    // The sweep owns the write port while it runs.
    always_comb begin
        w_mem_we    = w_wr_accept;
        w_mem_waddr = write_address;
        w_mem_wdata = write_data_in;
        if (w_sweep) begin
            w_mem_we    = 1'b1;
            w_mem_waddr = r_sweep_addr;
            w_mem_wdata = '0;
        end
    end

    // ------------------------------------------------------------------------
    // Memory array (no reset: contents survive resetn)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_waddr] <= w_mem_wdata;
        end
    end

    // ------------------------------------------------------------------------
    // Controller, sweep counter and first read stage
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= c_ST_RESET;
            r_sweep_addr <= '0;
            r_s1_valid   <= 1'b0;
            r_s1_data    <= '0;
            r_coll       <= 1'b0;
        end else begin
            r_coll     <= w_hit;
            r_s1_valid <= w_rd_fire;
            if (w_rd_fire) begin
                r_s1_data <= w_rd_value;
            end

            if (r_state == c_ST_CLEAR) begin
                // Counter parks on the last address instead of wrapping.
                if (r_sweep_addr == c_LAST_ADDR) begin
                    r_state <= c_ST_RUN;
                end else begin
                    r_sweep_addr <= r_sweep_addr + DEPTH_BITS'(1);
                end
            end
        end
    end

    assign init_busy = (r_state == c_ST_CLEAR);
    assign collision = r_coll;

    // ------------------------------------------------------------------------
    // Optional output register stage
    // ------------------------------------------------------------------------
    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic             r_s2_valid;
            logic [WIDTH-1:0] r_s2_data;

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    r_s2_valid <= 1'b0;
                    r_s2_data  <= '0;
                end else begin
                    r_s2_valid <= r_s1_valid;
                    if (r_s1_valid) begin
                        r_s2_data <= r_s1_data;
                    end
                end
            end

            assign read_valid    = r_s2_valid;
            assign read_data_out = r_s2_data;
        end else begin : g_direct_out
            assign read_valid    = r_s1_valid;
            assign read_data_out = r_s1_data;
        end
    endgenerate

endmodule
`default_nettype wire

// File: doc/memory_ram_sdp.md
MEMORY_RAM_SDP -- requirements
Module: memory_ram_sdp

Interface
REQ-001 Parameter WIDTH, default 8, bits per location (legal range 1..64).
REQ-002 Parameter DEPTH_BITS, default 2, address bits; number of locations is 2**DEPTH_BITS.
REQ-003 Parameter READ_MODE, default 0, collision policy: 0 read-first, 1 write-first, 2 no-change.
REQ-004 Parameter OUT_REG, default 0, extra output register stage: 0 absent, 1 present.
REQ-005 Parameter CLEAR_ON_RESET, default 1, zero-fill sweep after reset: 1 enabled, 0 disabled.
REQ-006 clk  input  1  single clock; all state changes on its rising edge.
REQ-007 resetn  input  1  reset, asynchronous and active-low.
REQ-008 write_en  input  1  write request for this cycle.
REQ-009 write_address  input  DEPTH_BITS  write location.
REQ-010 write_data_in  input  WIDTH  write data.
REQ-011 read_en  input  1  read request for this cycle.
REQ-012 read_address  input  DEPTH_BITS  read location.
REQ-013 read_data_out  output  WIDTH  registered read data.
REQ-014 read_valid  output  1  one-cycle pulse, read_data_out holds the result of an accepted read.
REQ-015 init_busy  output  1  high while the zero-fill sweep runs; requests are ignored.
REQ-016 collision  output  1  one-cycle pulse on an accepted same-address read and write.

Function
REQ-017 The block SHALL provide independent write and read ports that can both be accepted in the same cycle (simple dual port).
REQ-018 FSM states SHALL be CLEAR and RUN; reset enters CLEAR when CLEAR_ON_RESET=1, else RUN.
REQ-019 In CLEAR, an internal counter SHALL write 0 to address 0, 1, ... 2**DEPTH_BITS-1, one location per cycle, then go to RUN.
REQ-020 init_busy SHALL be 1 exactly while the state is CLEAR: 2**DEPTH_BITS cycles after resetn rises.
REQ-021 In CLEAR, write_en and read_en SHALL be ignored; no memory change from the ports and no read_valid.
REQ-022 In RUN, write_en=1 SHALL store write_data_in at write_address on the rising edge.
REQ-023 In RUN, read_en=1 SHALL be accepted; read latency SHALL be 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1).
REQ-024 read_valid SHALL pulse exactly once per accepted read, aligned to its data; back-to-back reads SHALL give back-to-back valids.
REQ-025 read_data_out SHALL hold its last value when no read completes.
REQ-026 A collision is an accepted read and write in the same cycle with read_address == write_address; collision SHALL pulse 1 cycle later in every mode.
REQ-027 On collision, READ_MODE=0 SHALL return the old contents.
REQ-028 On collision, READ_MODE=1 SHALL return write_data_in.
REQ-029 On collision, READ_MODE=2 SHALL suppress the read: read_data_out holds its value and read_valid stays 0 for that read.
REQ-030 With READ_MODE=2, the write SHALL still be performed on collision.
REQ-031 Reads of unwritten locations with CLEAR_ON_RESET=0 SHALL return undefined data and are not checked.
REQ-032 Addresses SHALL be used modulo 2**DEPTH_BITS; the sweep counter SHALL stop at the last address and not wrap.

Reset
REQ-033 resetn=0 SHALL immediately force read_data_out=0, read_valid=0, collision=0, and clear the pipeline and sweep counter.
REQ-034 While resetn=0, init_busy SHALL be 1 when CLEAR_ON_RESET=1 and 0 otherwise.
REQ-035 Memory contents SHALL NOT be cleared asynchronously; zeroing happens only through the sweep.
REQ-036 Reset asserted mid-sweep or mid-read SHALL discard in-flight reads; on release, the sweep SHALL restart from address 0.

Verification
REQ-037 Defaults, release reset -> init_busy high 4 cycles; then reads of addresses 0..3 return 0 with one read_valid each.
REQ-038 RUN, write 0xA5@1, next cycle read@1 -> 0xA5 with read_valid 1 cycle later (OUT_REG=0) or 2 cycles later (OUT_REG=1).
REQ-039 Mem[2]=0x11; same cycle write 0x22@2 and read@2 -> READ_MODE 0 gives 0x11, mode 1 gives 0x22, mode 2 holds output with no valid; collision pulses in all modes; mem[2]=0x22 afterwards.
REQ-040 DEPTH_BITS=4, WIDTH=16, write_en and read_en held during the sweep -> no memory change and no valid; post-sweep reads all return 0x0000.
REQ-041 Assert resetn low at sweep cycle 2 and during a 2-stage read -> outputs 0 at once; on release, 2**DEPTH_BITS busy cycles again and no stale read_valid.
REQ-042 OUT_REG=1, reads of addresses 0,1,2,3 on consecutive cycles -> 4 consecutive valids with data in issue order.
